// File: rtl/fsm_vector_driver.sv
// fsm_vector_driver: buffered vector playback and response checker for benchmark FSMs.
// Define FSM_DRV_MISR_EN to add a response MISR on the signature output.
module fsm_vector_driver #(
    parameter int X_W     = 13,
    parameter int Y_W     = 18,
    parameter int DEPTH   = 16,
    parameter int RST_CYC = 2,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [X_W-1:0]             load_x,
    input  logic [Y_W-1:0]             load_y,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       dut_rst,
    output logic [X_W-1:0]             dut_x,
    input  logic [Y_W-1:0]             dut_y,
    output logic [CNT_W-1:0]           err_count,
    output logic                       first_err_valid,
    output logic [$clog2(DEPTH)-1:0]   first_err_idx,
    output logic [Y_W-1:0]             signature
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {IDLE, RST_DUT, RUN, DRAIN, DONE} state_t;

    state_t         state;
    logic [X_W-1:0] mem_x [DEPTH];
    logic [Y_W-1:0] mem_y [DEPTH];
    logic [AW:0]    fill;
    logic [AW:0]    idx;
    logic [RW-1:0]  rcnt;
    logic           cmp_v;
    logic [AW-1:0]  cmp_idx;
    logic [Y_W-1:0] exp_y;
    logic           idle;
    logic           acc;
    logic           miss;
    logic           launch;

    assign idle       = state == IDLE || state == DONE;
    assign load_ready = !rst && idle && !clear && fill < (AW+1)'(DEPTH);
    assign acc        = load_valid && load_ready;
    assign miss       = cmp_v && dut_y != exp_y;
    assign launch     = idle && start && !clear;

    always_ff @(posedge clk)
        if (acc) begin
            mem_x[fill[AW-1:0]] <= load_x;
            mem_y[fill[AW-1:0]] <= load_y;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            fill            <= '0;
            idx             <= '0;
            rcnt            <= '0;
            cmp_v           <= 1'b0;
            cmp_idx         <= '0;
            exp_y           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            dut_rst         <= 1'b0;
            dut_x           <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            if (acc) fill <= fill + 1'b1;
            if (miss) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= cmp_idx;
                end
            end
            case (state)
                IDLE, DONE:
                    if (clear) begin
                        fill  <= '0;
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                        rcnt            <= '0;
                        // a load accepted alongside start joins this run
                        if (fill == '0 && !acc) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RST_DUT;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            dut_rst <= 1'b1;
                            dut_x   <= '0;
                        end
                    end
                RST_DUT:
                    if (rcnt == RW'(RST_CYC - 1)) begin
                        state   <= RUN;
                        dut_rst <= 1'b0;
                        idx     <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                RUN: begin
                    dut_x   <= mem_x[idx[AW-1:0]];
                    exp_y   <= mem_y[idx[AW-1:0]];
                    cmp_idx <= idx[AW-1:0];
                    cmp_v   <= 1'b1;
                    idx     <= idx + 1'b1;
                    if (idx == fill - 1'b1) state <= DRAIN;
                end
                DRAIN: begin
                    cmp_v <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end

`ifdef FSM_DRV_MISR_EN
    logic [Y_W-1:0] sig;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            sig <= '0;
        else if (launch)
            sig <= '0;
        else if (cmp_v)
            sig <= {sig[Y_W-2:0], sig[Y_W-1]} ^ dut_y ^ (Y_W'(sig[Y_W-1]) << 3);

    assign signature = sig;
`else
    logic unused_launch;
    assign unused_launch = launch;
    assign signature     = '0;
`endif
endmodule

// File: tb/tb_fsm_vector_driver.sv
// tb_fsm_vector_driver: directed self-checking bench for fsm_vector_driver.
module tb_fsm_vector_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [12:0] load_x = '0;
    logic [17:0] load_y = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        dut_rst;
    logic [12:0] dut_x;
    logic [17:0] dut_y;
    logic [7:0]  err_count;
    logic        first_err_valid;
    logic [3:0]  first_err_idx;
    logic [17:0] signature;

    int checks = 0;
    int failures = 0;
    logic [12:0] xv [16];

    always #5 clk = ~clk;

    function automatic logic [17:0] f(input logic [12:0] x);
        return {x[12:8], x} ^ 18'h15A5A;
    endfunction

    // golden FSM stand-in: combinational response to the registered stimulus
    assign dut_y = f(dut_x);

    fsm_vector_driver dut (
        .clk(clk), .rst(rst), .clear(clear),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_x(load_x), .load_y(load_y), .start(start),
        .busy(busy), .done(done), .dut_rst(dut_rst),
        .dut_x(dut_x), .dut_y(dut_y), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .signature(signature)
    );

    task automatic load_entry(input logic [12:0] x, input logic [17:0] y);
        @(negedge clk);
        load_valid = 1'b1;
        load_x = x;
        load_y = y;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_run(input bit noise, input bit wl, input logic [12:0] lx,
                          input logic [17:0] ly, output int bc, output int rc, output int lr);
        @(negedge clk);
        start = 1'b1;
        if (wl) begin
            load_valid = 1'b1;
            load_x = lx;
            load_y = ly;
        end
        @(negedge clk);
        start = 1'b0;
        load_valid = 1'b0;
        bc = 0;
        rc = 0;
        lr = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            bc += int'(busy);
            rc += int'(dut_rst);
            if (busy && load_ready) lr++;
            if (noise) begin
                start = bc < 4;
                load_valid = bc < 4;
            end
            @(negedge clk);
        end
        start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, dut_rst, load_ready, first_err_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, dut_rst, load_ready, first_err_valid});
        end
        checks++;
        if ({dut_x, err_count, first_err_idx, signature} !== '0) begin
            failures++;
            $display("FAIL reset_values: got %h expected 0", {dut_x, err_count, first_err_idx, signature});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_load_ready: got %b expected 1", load_ready);
        end
    endtask

    task automatic test_pass_run();
        int bc, rc, lr;
        for (int i = 0; i < 3; i++) load_entry(xv[i], f(xv[i]));
        do_run(1'b1, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 6) begin
            failures++;
            $display("FAIL pass_length: got done=%b busy_cycles=%0d expected done=1 busy_cycles=6", done, bc);
        end
        checks++;
        if (rc != 2) begin
            failures++;
            $display("FAIL pass_dut_rst: got %0d cycles expected 2", rc);
        end
        checks++;
        if (lr != 0) begin
            failures++;
            $display("FAIL busy_load_ready: got %0d ready cycles expected 0", lr);
        end
        checks++;
        if (err_count !== 8'd0 || first_err_valid !== 1'b0) begin
            failures++;
            $display("FAIL pass_errors: got err=%0d fev=%b expected err=0 fev=0", err_count, first_err_valid);
        end
        checks++;
        if (dut_x !== xv[2] || dut_rst !== 1'b0) begin
            failures++;
            $display("FAIL pass_hold: got x=%h rst=%b expected x=%h rst=0", dut_x, dut_rst, xv[2]);
        end
    endtask

    task automatic test_mismatch();
        int bc, rc, lr;
        do_clear();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL clear_done: got %b expected 0", done);
        end
        for (int i = 0; i < 4; i++) load_entry(xv[i], i == 2 ? f(xv[i]) ^ 18'h20 : f(xv[i]));
        for (int r = 0; r < 2; r++) begin
            do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
            checks++;
            if (done !== 1'b1 || bc != 7) begin
                failures++;
                $display("FAIL mismatch_length: got done=%b busy_cycles=%0d expected done=1 busy_cycles=7", done, bc);
            end
            checks++;
            if (err_count !== 8'd1 || first_err_valid !== 1'b1 || first_err_idx !== 4'd2) begin
                failures++;
                $display("FAIL mismatch_result: got err=%0d fev=%b idx=%0d expected err=1 fev=1 idx=2",
                         err_count, first_err_valid, first_err_idx);
            end
        end
    endtask

    task automatic test_full();
        int bc, rc, lr;
        do_clear();
        for (int i = 0; i < 16; i++) load_entry(xv[i], f(xv[i]));
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %b expected 0", load_ready);
        end
        load_entry(13'h1ABC, 18'h0);
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 19 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL full_run: got done=%b busy_cycles=%0d err=%0d expected done=1 busy_cycles=19 err=0",
                     done, bc, err_count);
        end
    endtask

    task automatic test_empty_start();
        int bc, rc, lr;
        do_clear();
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 0 || rc != 0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL empty_start: got done=%b busy=%0d rst=%0d err=%0d expected done=1 busy=0 rst=0 err=0",
                     done, bc, rc, err_count);
        end
    endtask

    task automatic test_start_and_load();
        int bc, rc, lr;
        do_clear();
        load_entry(xv[4], f(xv[4]));
        load_entry(xv[5], f(xv[5]));
        do_run(1'b0, 1'b1, xv[6], f(xv[6]) ^ 18'h1, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 6) begin
            failures++;
            $display("FAIL start_load_length: got done=%b busy_cycles=%0d expected done=1 busy_cycles=6", done, bc);
        end
        checks++;
        if (err_count !== 8'd1 || first_err_idx !== 4'd2 || dut_x !== xv[6]) begin
            failures++;
            $display("FAIL start_load_result: got err=%0d idx=%0d x=%h expected err=1 idx=2 x=%h",
                     err_count, first_err_idx, dut_x, xv[6]);
        end
    endtask

    task automatic test_start_and_clear();
        int bc, rc, lr;
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dut_rst !== 1'b0) begin
            failures++;
            $display("FAIL start_clear: got busy=%b done=%b rst=%b expected 0 0 0", busy, done, dut_rst);
        end
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 0) begin
            failures++;
            $display("FAIL start_clear_empty: got done=%b busy_cycles=%0d expected done=1 busy_cycles=0", done, bc);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, rc, lr;
        bit seen;
        do_clear();
        for (int i = 0; i < 8; i++) load_entry(xv[i], f(xv[i]) ^ 18'h3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (dut_x === xv[5]) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_reach: got seen=%b busy=%b expected 1 1", seen, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dut_rst, load_ready, first_err_valid, dut_x, err_count, first_err_idx} !== '0) begin
            failures++;
            $display("FAIL mid_run_reset: got %h expected 0",
                     {busy, done, dut_rst, load_ready, first_err_valid, dut_x, err_count, first_err_idx});
        end
        @(negedge clk);
        rst = 1'b0;
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (done !== 1'b1 || bc != 0 || rc != 0) begin
            failures++;
            $display("FAIL post_reset_empty: got done=%b busy=%0d rst=%0d expected done=1 busy=0 rst=0", done, bc, rc);
        end
    endtask

    task automatic test_misr();
        int bc, rc, lr;
        logic [17:0] sig1, model;
        do_clear();
        for (int i = 0; i < 4; i++) load_entry(xv[i + 8], f(xv[i + 8]));
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        sig1 = signature;
`ifdef FSM_DRV_MISR_EN
        model = '0;
        for (int i = 0; i < 4; i++)
            model = {model[16:0], model[17]} ^ f(xv[i + 8]) ^ (18'(model[17]) << 3);
        checks++;
        if (sig1 !== model || sig1 === 18'h0) begin
            failures++;
            $display("FAIL misr_value: got %h expected %h (nonzero)", sig1, model);
        end
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (signature !== model) begin
            failures++;
            $display("FAIL misr_repeat: got %h expected %h", signature, model);
        end
        do_clear();
        for (int i = 0; i < 4; i++) load_entry(xv[i + 8], i == 1 ? f(xv[i + 8]) ^ 18'h400 : f(xv[i + 8]));
        do_run(1'b0, 1'b0, '0, '0, bc, rc, lr);
        checks++;
        if (signature !== model || err_count !== 8'd1 || first_err_idx !== 4'd1) begin
            failures++;
            $display("FAIL misr_flip: got sig=%h err=%0d idx=%0d expected sig=%h err=1 idx=1",
                     signature, err_count, first_err_idx, model);
        end
`else
        model = '0;
        checks++;
        if (sig1 !== model || done !== 1'b1) begin
            failures++;
            $display("FAIL sig_tied: got sig=%h done=%b expected sig=0 done=1", sig1, done);
        end
`endif
    endtask

    initial begin
        xv = '{13'h0001, 13'h1FFF, 13'h0AAA, 13'h1555, 13'h0F0F, 13'h10F0, 13'h0123, 13'h1234,
               13'h0ABC, 13'h1DEF, 13'h0800, 13'h0400, 13'h00FF, 13'h1F00, 13'h0777, 13'h1888};
        test_reset();
        test_pass_run();
        test_mismatch();
        test_full();
        test_empty_start();
        test_start_and_load();
        test_start_and_clear();
        test_reset_mid_run();
        test_misr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
